// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer: steps IDLE -> RUN -> DONE, applies
// sequential/absolute/relative PC updates and counts retired instructions.
module pc_fetch_ctrl #(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned OFF_W     = 8,
  parameter int unsigned LAST_ADDR = 1023,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             abs_jump,
  input  logic [PC_W-1:0]  abs_target,
  input  logic             rel_jump,
  input  logic [OFF_W-1:0] rel_offset,
  input  logic             halt,
  output logic [PC_W-1:0]  prog_ctr,
  output logic             fetch_en,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_nxt;
  logic             fetch_en_nxt;
  logic             done_nxt;
  logic [CNT_W-1:0] retired_nxt;
  logic [PC_W-1:0]  off_ext;
  logic [PC_W-1:0]  last_pc;

  // Signed offset widened to PC width; addition then wraps modulo 2**PC_W.
  assign off_ext = PC_W'($signed(rel_offset));
  assign last_pc = PC_W'(LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      fetch_en <= 1'b0;
      done     <= 1'b0;
      retired  <= '0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      fetch_en <= fetch_en_nxt;
      done     <= done_nxt;
      retired  <= retired_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = prog_ctr;
    fetch_en_nxt = fetch_en;
    done_nxt     = done;
    retired_nxt  = retired;

    case (state)
      IDLE: begin
        fetch_en_nxt = 1'b0;
        done_nxt     = 1'b0;
        if (start) begin
          state_nxt    = RUN;
          pc_nxt       = '0;
          retired_nxt  = '0;
          fetch_en_nxt = 1'b1;
        end
      end

      RUN: begin
        // Stall freezes everything; the decoder re-presents its request.
        if (!stall) begin
          if (retired != {CNT_W{1'b1}}) begin
            retired_nxt = retired + CNT_W'(1);
          end
          if (halt) begin
            state_nxt    = DONE;
            done_nxt     = 1'b1;
            fetch_en_nxt = 1'b0;
          end else if (abs_jump) begin
            pc_nxt = abs_target;
          end else if (rel_jump) begin
            pc_nxt = prog_ctr + off_ext;
          end else if (prog_ctr == last_pc) begin
            state_nxt    = DONE;
            done_nxt     = 1'b1;
            fetch_en_nxt = 1'b0;
          end else begin
            pc_nxt = prog_ctr + PC_W'(1);
          end
        end
      end

      DONE: begin
        done_nxt     = 1'b1;
        fetch_en_nxt = 1'b0;
        if (start) begin
          state_nxt    = RUN;
          pc_nxt       = '0;
          retired_nxt  = '0;
          done_nxt     = 1'b0;
          fetch_en_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt    = IDLE;
        pc_nxt       = '0;
        fetch_en_nxt = 1'b0;
        done_nxt     = 1'b0;
        retired_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed, table-driven bench for pc_fetch_ctrl; a narrow-counter copy of
// the design shares the stimulus so counter saturation is reachable.
module tb_pc_fetch_ctrl;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned OFF_W = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned SAT_W = 3;

  typedef struct {
    logic             rst;
    logic             st;
    logic             stl;
    logic             aj;
    logic [PC_W-1:0]  at;
    logic             rj;
    logic [OFF_W-1:0] ro;
    logic             h;
    logic [PC_W-1:0]  epc;
    logic             efe;
    logic             ed;
    logic [CNT_W-1:0] er;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stall;
  logic             abs_jump;
  logic [PC_W-1:0]  abs_target;
  logic             rel_jump;
  logic [OFF_W-1:0] rel_offset;
  logic             halt;
  logic [PC_W-1:0]  prog_ctr;
  logic             fetch_en;
  logic             done;
  logic [CNT_W-1:0] retired;
  logic [PC_W-1:0]  sat_pc;
  logic             sat_fe;
  logic             sat_done;
  logic [SAT_W-1:0] sat_ret;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .abs_jump(abs_jump), .abs_target(abs_target),
    .rel_jump(rel_jump), .rel_offset(rel_offset), .halt(halt),
    .prog_ctr(prog_ctr), .fetch_en(fetch_en), .done(done), .retired(retired)
  );

  pc_fetch_ctrl #(.CNT_W(SAT_W)) u_sat (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .abs_jump(abs_jump), .abs_target(abs_target),
    .rel_jump(rel_jump), .rel_offset(rel_offset), .halt(halt),
    .prog_ctr(sat_pc), .fetch_en(sat_fe), .done(sat_done), .retired(sat_ret)
  );

  task automatic add(input logic rst, input logic st, input logic stl,
                     input logic aj, input int at, input logic rj,
                     input logic [OFF_W-1:0] ro, input logic h,
                     input int epc, input logic efe, input logic ed, input int er);
    vec_t v;
    v.rst = rst; v.st = st; v.stl = stl; v.aj = aj; v.at = PC_W'(at);
    v.rj = rj; v.ro = ro; v.h = h;
    v.epc = PC_W'(epc); v.efe = efe; v.ed = ed; v.er = CNT_W'(er);
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; start = v.st; stall = v.stl; abs_jump = v.aj;
    abs_target = v.at; rel_jump = v.rj; rel_offset = v.ro; halt = v.h;
  endtask

  task automatic idle_inputs();
    reset = 1'b1; start = 1'b0; stall = 1'b0; abs_jump = 1'b0;
    abs_target = '0; rel_jump = 1'b0; rel_offset = '0; halt = 1'b0;
  endtask

  // One comparison of every observable output against expectations.
  task automatic check(input string name, input logic [PC_W-1:0] epc,
                       input logic efe, input logic ed, input logic [CNT_W-1:0] er);
    logic [SAT_W-1:0] esat;
    esat = (er > CNT_W'(7)) ? SAT_W'(7) : SAT_W'(er);
    total++;
    if (prog_ctr !== epc || fetch_en !== efe || done !== ed || retired !== er ||
        sat_pc !== epc || sat_fe !== efe || sat_done !== ed || sat_ret !== esat) begin
      bad++;
      $display("FAIL %s: got pc=%0d fe=%0b done=%0b ret=%0d sat_ret=%0d; want pc=%0d fe=%0b done=%0b ret=%0d sat_ret=%0d",
               name, prog_ctr, fetch_en, done, retired, sat_ret, epc, efe, ed, er, esat);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i]);
      step();
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].efe, vecs[i].ed, vecs[i].er);
    end
  endtask

  int mark_hold;
  int mark_idle;

  initial begin
    idle_inputs();
    reset = 1'b0;

    //  rst st stl aj at   rj ro     h   pc   fe d  ret
    add(0, 0, 0, 0, 0,    0, 8'h00, 0,  0,   0, 0, 0);
    add(0, 0, 0, 0, 0,    0, 8'h00, 0,  0,   0, 0, 0);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  0,   0, 0, 0);
    add(1, 0, 0, 1, 55,   0, 8'h00, 1,  0,   0, 0, 0);   // IDLE ignores decoder
    add(1, 1, 0, 0, 0,    0, 8'h00, 0,  0,   1, 0, 0);   // start
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  1,   1, 0, 1);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  2,   1, 0, 2);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  3,   1, 0, 3);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  4,   1, 0, 4);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  5,   1, 0, 5);
    add(1, 0, 0, 0, 0,    1, 8'hFD, 0,  2,   1, 0, 6);   // 5-3
    add(1, 0, 0, 0, 0,    1, 8'd10, 0,  12,  1, 0, 7);   // 2+10
    add(1, 0, 0, 1, 1,    0, 8'h00, 0,  1,   1, 0, 8);
    add(1, 0, 0, 0, 0,    1, 8'hFD, 0,  1022,1, 0, 9);   // 1-3 wraps
    add(1, 0, 0, 1, 7,    0, 8'h00, 0,  7,   1, 0, 10);
    add(1, 0, 0, 1, 100,  1, 8'h03, 0,  100, 1, 0, 11);  // abs beats rel
    add(1, 0, 0, 1, 7,    0, 8'h00, 0,  7,   1, 0, 12);
    add(1, 0, 1, 0, 0,    1, 8'h05, 0,  7,   1, 0, 12);  // stall beats rel
    add(1, 0, 1, 1, 300,  0, 8'h00, 1,  7,   1, 0, 12);  // stall beats halt
    add(1, 1, 0, 0, 0,    0, 8'h00, 0,  8,   1, 0, 13);  // start ignored in RUN
    add(1, 0, 0, 1, 20,   0, 8'h00, 0,  20,  1, 0, 14);
    add(1, 0, 0, 1, 9,    1, 8'h01, 1,  20,  0, 1, 15);  // halt beats jumps
    add(1, 0, 0, 1, 5,    1, 8'h01, 0,  20,  0, 1, 15);  // DONE frozen
    mark_hold = vecs.size();
    add(1, 1, 0, 0, 0,    0, 8'h00, 0,  0,   1, 0, 0);   // restart from DONE
    add(1, 0, 0, 1, 1021, 0, 8'h00, 0,  1021,1, 0, 1);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  1022,1, 0, 2);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  1023,1, 0, 3);
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  1023,0, 1, 4);   // fell off LAST_ADDR
    add(1, 1, 0, 0, 0,    0, 8'h00, 0,  0,   1, 0, 0);
    add(1, 0, 0, 1, 1023, 0, 8'h00, 0,  1023,1, 0, 1);
    add(1, 0, 0, 0, 0,    1, 8'h02, 0,  1,   1, 0, 2);   // rel at LAST_ADDR wraps up
    add(1, 0, 0, 1, 1023, 0, 8'h00, 0,  1023,1, 0, 3);
    add(1, 0, 0, 1, 500,  0, 8'h00, 0,  500, 1, 0, 4);   // abs at LAST_ADDR
    add(1, 0, 0, 1, 37,   0, 8'h00, 0,  37,  1, 0, 5);
    add(0, 1, 0, 0, 0,    0, 8'h00, 0,  0,   0, 0, 0);   // reset mid-RUN
    add(1, 0, 0, 0, 0,    0, 8'h00, 0,  0,   0, 0, 0);
    mark_idle = vecs.size();

    run_table(0, mark_hold);

    // DONE must hold across ten quiet cycles.
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("done_hold%0d", i), PC_W'(20), 1'b0, 1'b1, CNT_W'(15));
    end

    run_table(mark_hold, mark_idle);

    // After reset the block waits in IDLE until start.
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("idle_wait%0d", i), PC_W'(0), 1'b0, 1'b0, CNT_W'(0));
    end
    start = 1'b1;
    step();
    check("resume_start", PC_W'(0), 1'b1, 1'b0, CNT_W'(0));
    start = 1'b0;
    step();
    check("resume_step", PC_W'(1), 1'b1, 1'b0, CNT_W'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
